// File: rtl/chacha20_block_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : chacha20_block_scheduler
//  Description : Drives the serial ChaCha20 round core to produce a run of
//                512-bit keystream blocks. For each block it builds the
//                initial state, pulses the core's set_state, waits out the
//                round latency, applies the feed-forward add and offers the
//                block on a valid/ready port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, clear_n        clock, asynchronous active-low reset
//    start, abort          job request strobe / job cancel
//    key, nonce            256-bit key, 96-bit nonce (captured at start)
//    counter_init          block counter of the first block
//    num_blocks            number of blocks to generate (0 = no-op)
//    busy, done, wrap_err  status: not idle / end-of-job pulse / counter wrap
//    enc_set_state         load strobe to the round core
//    enc_clear             clear to the round core
//    enc_round_input       initial state to the round core
//    enc_round_output      20-round result from the round core
//    ks_valid, ks_ready    keystream handshake
//    ks_data, ks_counter   keystream block and the counter it was made with
// ============================================================================
module chacha20_block_scheduler #(
    parameter int ROUND_CYCLES = 80,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             abort,
    input  logic [255:0]     key,
    input  logic [95:0]      nonce,
    input  logic [31:0]      counter_init,
    input  logic [CNT_W-1:0] num_blocks,
    output logic             busy,
    output logic             done,
    output logic             wrap_err,
    output logic             enc_set_state,
    output logic             enc_clear,
    output logic [511:0]     enc_round_input,
    input  logic [511:0]     enc_round_output,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [511:0]     ks_data,
    output logic [31:0]      ks_counter
);

    localparam int              CYC_W      = $clog2(ROUND_CYCLES + 1);
    localparam logic [CYC_W-1:0] C_RUN_LAST = CYC_W'(ROUND_CYCLES - 1);
    // "expand 32-byte k", word 0 in the low bits
    localparam logic [127:0]    C_SIGMA    = {32'h6b206574, 32'h79622d32,
                                              32'h3320646e, 32'h61707865};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_ADD  = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [511:0]       r_init;
    logic [511:0]       r_ks_data;
    logic [CNT_W-1:0]   r_remaining;
    logic [CYC_W-1:0]   r_cyc;
    logic               r_wrap_err;
    logic               r_enc_clear;
    logic [511:0]       w_sum;
    logic               w_abort;
    logic               w_last;
    logic               w_wrap;

    // Word 12 of the held initial state doubles as the live block counter.
    assign w_abort = abort && (r_state != S_IDLE);
    assign w_last  = (r_remaining == CNT_W'(1));
    assign w_wrap  = (r_init[415:384] == 32'hFFFF_FFFF);

    // Feed-forward add: independent 32-bit sums, no carry across words.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_add
            assign w_sum[32*i +: 32] = enc_round_output[32*i +: 32] + r_init[32*i +: 32];
        end
    endgenerate

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        enc_set_state = (r_state == S_LOAD);
        ks_valid      = (r_state == S_OUT);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_blocks == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
                if (r_cyc == C_RUN_LAST) begin
                    w_next = S_ADD;
                end
            end
            S_ADD:  w_next = S_OUT;
            S_OUT: begin
                if (ks_ready) begin
                    w_next = (w_last || w_wrap) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_init      <= '0;
            r_ks_data   <= '0;
            r_remaining <= '0;
            r_cyc       <= '0;
            r_wrap_err  <= 1'b0;
            r_enc_clear <= 1'b1;
        end else begin
            r_enc_clear <= w_abort;
            if (!w_abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_wrap_err <= 1'b0;
                            if (num_blocks != '0) begin
                                r_init      <= {nonce, counter_init, key, C_SIGMA};
                                r_remaining <= num_blocks;
                            end
                        end
                    end
                    S_LOAD: r_cyc <= '0;
                    S_RUN:  r_cyc <= r_cyc + CYC_W'(1);
                    S_ADD:  r_ks_data <= w_sum;
                    S_OUT: begin
                        if (ks_ready) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                            if (!w_last) begin
                                if (w_wrap) begin
                                    r_wrap_err <= 1'b1;
                                end else begin
                                    r_init[415:384] <= r_init[415:384] + 32'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wrap_err        = r_wrap_err;
    assign enc_clear       = r_enc_clear;
    assign enc_round_input = r_init;
    assign ks_data         = r_ks_data;
    assign ks_counter      = r_init[415:384];

endmodule
`default_nettype wire

// File: tb/tb_chacha20_block_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chacha20_block_scheduler
//  Description : Self-checking bench for chacha20_block_scheduler. A
//                behavioural ChaCha20 round core answers set_state after
//                ROUND_CYCLES; expected keystream comes from a reference
//                block function built directly from the ChaCha20 rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha20_block_scheduler;

    localparam int RC    = 80;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             clear_n, start, abort, ks_ready;
    logic [255:0]     key;
    logic [95:0]      nonce;
    logic [31:0]      counter_init;
    logic [CNT_W-1:0] num_blocks;
    logic             busy, done, wrap_err, enc_set_state, enc_clear, ks_valid;
    logic [511:0]     enc_round_input, enc_round_output, ks_data;
    logic [31:0]      ks_counter;

    int n_checks = 0;
    int n_fail   = 0;
    int set_cnt  = 0;

    localparam logic [255:0] RFC_KEY   = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [95:0]  RFC_NONCE = 96'h00000000_4a000000_09000000;

    always #5 clock = ~clock;

    chacha20_block_scheduler #(.ROUND_CYCLES(RC), .CNT_W(CNT_W)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .abort(abort),
        .key(key), .nonce(nonce), .counter_init(counter_init), .num_blocks(num_blocks),
        .busy(busy), .done(done), .wrap_err(wrap_err),
        .enc_set_state(enc_set_state), .enc_clear(enc_clear),
        .enc_round_input(enc_round_input), .enc_round_output(enc_round_output),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_counter(ks_counter)
    );

    // ---------------- reference ChaCha20 ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_rounds(input logic [511:0] s);
        logic [31:0]  x [16];
        int           q [8][4];
        logic [127:0] t;
        logic [511:0] o;
        q = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
              '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 8; k++) begin
                t = qr(x[q[k][0]], x[q[k][1]], x[q[k][2]], x[q[k][3]]);
                x[q[k][0]] = t[127:96]; x[q[k][1]] = t[95:64];
                x[q[k][2]] = t[63:32];  x[q[k][3]] = t[31:0];
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
        return o;
    endfunction

    function automatic logic [511:0] init_state(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        logic [31:0]  w [16];
        logic [511:0] o;
        w[0] = 32'h61707865; w[1] = 32'h3320646e; w[2] = 32'h79622d32; w[3] = 32'h6b206574;
        for (int j = 0; j < 8; j++) w[4+j] = k[32*j +: 32];
        w[12] = c;
        for (int j = 0; j < 3; j++) w[13+j] = n[32*j +: 32];
        for (int i = 0; i < 16; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    function automatic logic [511:0] keystream(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        logic [511:0] s, r, o;
        s = init_state(k, n, c);
        r = chacha_rounds(s);
        for (int i = 0; i < 16; i++) o[32*i +: 32] = r[32*i +: 32] + s[32*i +: 32];
        return o;
    endfunction

    // ---------------- behavioural round core ----------------
    logic [511:0] core_res;
    int           core_cnt   = 0;
    logic         core_armed = 1'b0;

    always @(posedge clock) begin
        if (enc_set_state) begin
            core_res         <= chacha_rounds(enc_round_input);
            core_cnt         <= 0;
            core_armed       <= 1'b1;
            enc_round_output <= ~enc_round_input;   // garbage until latency expires
            set_cnt          <= set_cnt + 1;
        end else if (core_armed) begin
            if (core_cnt == RC - 1) begin
                enc_round_output <= core_res;
                core_armed       <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        clear_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
        key = '0; nonce = '0; counter_init = '0; num_blocks = '0;
        tick; tick;
        n_checks++; if ({busy, done, wrap_err, enc_set_state, ks_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, wrap_err, enc_set_state, ks_valid}); end
        n_checks++; if (enc_clear !== 1'b1) begin n_fail++; $display("FAIL reset_enc_clear: got %b expected 1", enc_clear); end
        n_checks++; if (ks_data !== '0 || ks_counter !== '0) begin n_fail++; $display("FAIL reset_ks: got %h/%h expected 0", ks_data, ks_counter); end
        n_checks++; if (enc_round_input !== '0) begin n_fail++; $display("FAIL reset_round_input: got %h expected 0", enc_round_input); end
        clear_n = 1'b1;
        tick;
        n_checks++; if (busy !== 1'b0 || enc_clear !== 1'b0) begin n_fail++; $display("FAIL post_reset: got busy=%b clr=%b expected 0 0", busy, enc_clear); end
    endtask

    task automatic test_rfc_vector;
        logic [511:0] exp, got;
        logic [31:0]  got_ctr;
        int           first, dcount;
        exp = keystream(RFC_KEY, RFC_NONCE, 32'd1);
        key = RFC_KEY; nonce = RFC_NONCE; counter_init = 32'd1; num_blocks = CNT_W'(1);
        ks_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++; if (enc_set_state !== 1'b1) begin n_fail++; $display("FAIL rfc_load_pulse: got %b expected 1", enc_set_state); end
        n_checks++; if (enc_round_input !== init_state(RFC_KEY, RFC_NONCE, 32'd1)) begin n_fail++; $display("FAIL rfc_init_state: got %h expected %h", enc_round_input, init_state(RFC_KEY, RFC_NONCE, 32'd1)); end
        key = rand256(); nonce = {$urandom, $urandom, $urandom}; counter_init = $urandom; num_blocks = CNT_W'($urandom);
        first = 0; dcount = 0; got = '0; got_ctr = '0;
        for (int c = 1; c <= RC + 12; c++) begin
            if (ks_valid && first == 0) begin first = c; got = ks_data; got_ctr = ks_counter; end
            if (done) dcount++;
            tick;
        end
        n_checks++; if (first != RC + 3) begin n_fail++; $display("FAIL rfc_latency: got %0d expected %0d", first, RC + 3); end
        n_checks++; if (got[31:0] !== 32'he4e7f110) begin n_fail++; $display("FAIL rfc_word0: got %h expected e4e7f110", got[31:0]); end
        n_checks++; if (got[511:480] !== 32'h4e3c50a2) begin n_fail++; $display("FAIL rfc_word15: got %h expected 4e3c50a2", got[511:480]); end
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rfc_block: got %h expected %h", got, exp); end
        n_checks++; if (got_ctr !== 32'd1) begin n_fail++; $display("FAIL rfc_counter: got %h expected 1", got_ctr); end
        n_checks++; if (dcount != 1) begin n_fail++; $display("FAIL rfc_done_count: got %0d expected 1", dcount); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rfc_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_job(input string name, input logic [31:0] ctr, input int n, input bit stall, input bit check_period);
        logic [255:0] k0;
        logic [95:0]  n0;
        longint       room;
        int           nexp, k, dcount, endc, last_rise, budget;
        bit           exp_wrap, held;
        logic [511:0] hold_d;
        logic [31:0]  hold_c;
        k0 = rand256(); n0 = {$urandom, $urandom, $urandom};
        room = 64'h1_0000_0000 - longint'(ctr);
        nexp = (longint'(n) > room) ? int'(room) : n;
        exp_wrap = (longint'(n) > room);
        budget = nexp * (RC + 3) * 3 + 30;
        key = k0; nonce = n0; counter_init = ctr; num_blocks = CNT_W'(n);
        ks_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        key = rand256(); nonce = {$urandom, $urandom, $urandom}; counter_init = $urandom; num_blocks = CNT_W'($urandom);
        k = 0; dcount = 0; endc = 0; last_rise = 0; held = 1'b0; hold_d = '0; hold_c = '0;
        for (int c = 1; c <= budget; c++) begin
            ks_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (held) begin
                n_checks++; if (ks_valid !== 1'b1 || ks_data !== hold_d || ks_counter !== hold_c) begin n_fail++; $display("FAIL %s_stall_hold: got v=%b ctr=%h expected v=1 ctr=%h", name, ks_valid, ks_counter, hold_c); end
            end
            if (ks_valid && !held) begin
                n_checks++; if (k >= nexp) begin n_fail++; $display("FAIL %s_extra_block: got block %0d ctr=%h expected only %0d blocks", name, k, ks_counter, nexp); end
                n_checks++; if (ks_counter !== 32'(ctr + k)) begin n_fail++; $display("FAIL %s_counter: got %h expected %h", name, ks_counter, 32'(ctr + k)); end
                n_checks++; if (ks_data !== keystream(k0, n0, 32'(ctr + k))) begin n_fail++; $display("FAIL %s_data: got %h expected %h", name, ks_data, keystream(k0, n0, 32'(ctr + k))); end
                if (check_period) begin
                    n_checks++; if (c - last_rise != RC + 3) begin n_fail++; $display("FAIL %s_period: got %0d expected %0d", name, c - last_rise, RC + 3); end
                end
                last_rise = c; hold_d = ks_data; hold_c = ks_counter;
            end
            if (ks_valid && ks_ready) begin k++; held = 1'b0; end
            else held = ks_valid;
            if (done) begin dcount++; if (dcount == 1) endc = c; end
            tick;
            if (dcount > 0 && c > endc + 3) break;
        end
        ks_ready = 1'b1;
        n_checks++; if (k != nexp) begin n_fail++; $display("FAIL %s_block_count: got %0d expected %0d", name, k, nexp); end
        n_checks++; if (dcount != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d expected 1", name, dcount); end
        n_checks++; if (wrap_err !== exp_wrap) begin n_fail++; $display("FAIL %s_wrap_err: got %b expected %b", name, wrap_err, exp_wrap); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after: got %b expected 0", name, busy); end
    endtask

    task automatic test_zero_and_busy_start;
        int s0, hs, dcount;
        logic [31:0] got_ctr;
        n_checks++; if (wrap_err !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got %b expected 1", wrap_err); end
        s0 = set_cnt;
        num_blocks = '0; start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || wrap_err !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b wrap=%b expected 1 0", done, wrap_err); end
        tick;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy); end
        tick;
        n_checks++; if (set_cnt != s0) begin n_fail++; $display("FAIL zero_set_state: got %0d pulses expected 0", set_cnt - s0); end
        // a second start while busy must not disturb the running job
        s0 = set_cnt;
        key = rand256(); counter_init = 32'd100; num_blocks = CNT_W'(1); ks_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        counter_init = 32'd500; num_blocks = CNT_W'(5); start = 1'b1;
        tick;
        start = 1'b0;
        hs = 0; dcount = 0; got_ctr = '0;
        for (int c = 0; c < RC + 20; c++) begin
            if (ks_valid && ks_ready) begin hs++; got_ctr = ks_counter; end
            if (done) dcount++;
            tick;
        end
        n_checks++; if (hs != 1 || got_ctr !== 32'd100) begin n_fail++; $display("FAIL busy_start_blocks: got %0d blocks ctr=%h expected 1 ctr=00000064", hs, got_ctr); end
        n_checks++; if (dcount != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_done: got done=%0d busy=%b expected 1 0", dcount, busy); end
        n_checks++; if (set_cnt - s0 != 1) begin n_fail++; $display("FAIL busy_start_loads: got %0d expected 1", set_cnt - s0); end
    endtask

    task automatic test_abort;
        int clr, dn, vs, w;
        for (int m = 0; m < 2; m++) begin
            key = rand256(); counter_init = 32'd5; num_blocks = CNT_W'(2);
            ks_ready = (m == 0); start = 1'b1;
            tick;
            start = 1'b0;
            if (m == 0) begin
                repeat (10) tick;
            end else begin
                w = 0;
                while (!ks_valid && w < RC + 10) begin tick; w++; end
                n_checks++; if (ks_valid !== 1'b1) begin n_fail++; $display("FAIL abort_reach_out: got valid=%b expected 1", ks_valid); end
            end
            abort = 1'b1;
            tick;
            abort = 1'b0;
            n_checks++; if (busy !== 1'b0 || ks_valid !== 1'b0 || enc_clear !== 1'b1) begin n_fail++; $display("FAIL abort_%0d_next: got busy=%b v=%b clr=%b expected 0 0 1", m, busy, ks_valid, enc_clear); end
            clr = 0; dn = 0; vs = 0;
            for (int c = 0; c < RC + 10; c++) begin
                clr += int'(enc_clear); dn += int'(done); vs += int'(ks_valid);
                tick;
            end
            n_checks++; if (clr != 1 || dn != 0 || vs != 0) begin n_fail++; $display("FAIL abort_%0d_after: got clr=%0d done=%0d valid=%0d expected 1 0 0", m, clr, dn, vs); end
        end
        ks_ready = 1'b1;
    endtask

    task automatic test_async_reset;
        int w;
        key = rand256(); counter_init = $urandom; num_blocks = CNT_W'(2); ks_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        w = 0;
        while (!ks_valid && w < RC + 10) begin tick; w++; end
        n_checks++; if (ks_valid !== 1'b1) begin n_fail++; $display("FAIL areset_reach_out: got valid=%b expected 1", ks_valid); end
        @(negedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, wrap_err, enc_set_state, ks_valid} !== 5'b0 || enc_clear !== 1'b1) begin n_fail++; $display("FAIL areset_flags: got %b clr=%b expected 00000 1", {busy, done, wrap_err, enc_set_state, ks_valid}, enc_clear); end
        n_checks++; if (ks_data !== '0 || ks_counter !== '0 || enc_round_input !== '0) begin n_fail++; $display("FAIL areset_data: got ctr=%h expected all zero", ks_counter); end
        @(negedge clock);
        clear_n = 1'b1;
        ks_ready = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_rfc_vector;
        test_job("stall", 32'd7, 3, 1'b1, 1'b0);
        test_job("b2b", $urandom, 2, 1'b0, 1'b1);
        test_job("wrap", 32'hFFFF_FFFE, 4, 1'b0, 1'b0);
        test_zero_and_busy_start;
        test_abort;
        test_rfc_vector;
        test_async_reset;
        test_job("post_reset", $urandom, 1, 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
